// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers: a fixed-latency busy window per
// operation, then the result is written to HI/LO on the edge where busy falls.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  md_op,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        o_dbg_state
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_op;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic [31:0]   w_mag_a;
   logic [31:0]   w_mag_b;
   logic [31:0]   w_sq;
   logic [31:0]   w_sr;
   logic [31:0]   w_uq;
   logic [31:0]   w_ur;
   logic [31:0]   w_res_hi;
   logic [31:0]   w_res_lo;
   logic          w_res_wr;

   // Signed division is done on magnitudes so 0x80000000 / -1 wraps to
   // 0x80000000 without relying on two's-complement overflow behaviour.
   always_comb begin
      w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
      w_prod_u = {32'b0, r_a} * {32'b0, r_b};
      w_mag_a  = r_a[31] ? (32'd0 - r_a) : r_a;
      w_mag_b  = r_b[31] ? (32'd0 - r_b) : r_b;
      w_sq     = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a / w_mag_b);
      w_sr     = (w_mag_b == 32'd0) ? 32'd0 : (w_mag_a % w_mag_b);
      w_uq     = (r_b == 32'd0) ? 32'd0 : (r_a / r_b);
      w_ur     = (r_b == 32'd0) ? 32'd0 : (r_a % r_b);
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      w_res_wr = 1'b0;
      case (r_op)
         OP_MULT: begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
            w_res_wr = 1'b1;
         end
         OP_MULTU: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
            w_res_wr = 1'b1;
         end
         OP_DIV: begin
            w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_sq) : w_sq;
            w_res_hi = r_a[31] ? (32'd0 - w_sr) : w_sr;
            w_res_wr = (r_b != 32'd0);
         end
         OP_DIVU: begin
            w_res_lo = w_uq;
            w_res_hi = w_ur;
            w_res_wr = (r_b != 32'd0);
         end
         default: begin
            w_res_wr = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_op    <= 3'b000;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  case (md_op)
                     OP_MULT, OP_MULTU: begin
                        r_op    <= md_op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= CW'(MULT_CYCLES);
                        r_state <= ST_RUN;
                     end
                     OP_DIV, OP_DIVU: begin
                        r_op    <= md_op;
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt   <= CW'(DIV_CYCLES);
                        r_state <= ST_RUN;
                     end
                     OP_MTHI: r_hi <= a;
                     OP_MTLO: r_lo <= a;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               // Last busy cycle: commit the result and drop back to IDLE together.
               if (r_cnt <= CW'(1)) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
                  if (w_res_wr) begin
                     r_hi <= w_res_hi;
                     r_lo <= w_res_lo;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (r_state == ST_RUN);
   assign o_dbg_state = r_state;
   assign hi          = r_hi;
   assign lo          = r_lo;

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, number of busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, number of busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a  input  32  rs operand, taken from the forwarding-mux output.
REQ-006 SHALL have port b  input  32  rt operand, taken from the forwarding-mux output.
REQ-007 SHALL have port md_op  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none).
REQ-008 SHALL have port start  input  1  qualifies md_op for one cycle.
REQ-009 SHALL have port busy  output  1  high while a mult/div is in progress.
REQ-010 SHALL have port hi  output  32  HI register, registered.
REQ-011 SHALL have port lo  output  32  LO register, registered.

Function
REQ-012 SHALL implement two states, IDLE and RUN; busy = 1 exactly when in RUN.
REQ-013 In IDLE, start=1 with md_op mult/multu/div/divu SHALL capture a, b and the op at that edge, load a down-counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-014 busy SHALL be high for exactly N consecutive cycles beginning the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-015 hi/lo SHALL update with the result at the edge where busy falls, not earlier; intermediate values SHALL never appear on hi/lo.
REQ-016 mult SHALL give the signed 64-bit product of a and b; multu the unsigned product; hi = bits 63:32, lo = bits 31:0.
REQ-017 div SHALL give lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend; divu SHALL give the unsigned quotient and remainder.
REQ-018 div 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0x00000000.
REQ-019 Division by zero SHALL still run the full DIV_CYCLES busy period and SHALL leave hi and lo unchanged.
REQ-020 In IDLE, start=1 with md_op mthi (or mtlo) SHALL write a into hi (or lo) at that edge; busy stays 0.
REQ-021 start=1 while in RUN SHALL be ignored for every md_op, including mthi/mtlo; the hazard unit stalls on busy.
REQ-022 Operand changes on a/b after the accepting edge SHALL not affect the result.
REQ-023 start=1 with md_op none/reserved SHALL have no effect.
REQ-024 The unit SHALL return to IDLE on the edge busy falls and SHALL accept a new start on the next edge.
REQ-025 A start in the first cycle after busy falls SHALL be accepted.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state IDLE, counter 0, busy 0, hi 0x00000000, lo 0x00000000.
REQ-027 reset asserted mid-operation SHALL discard the pending result; after release hi/lo stay 0 until a new operation completes.
REQ-028 start sampled on the first rising edge after reset deassertion SHALL be honoured.

Verification
REQ-029 mult a=0xFFFFFFFE (-2), b=0x00000003 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-030 multu a=0xFFFFFFFF, b=0x00000002 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 div a=0xFFFFFFF9 (-7), b=0x00000002 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-032 mthi a=0x12345678, then div by b=0 -> busy 10 cycles, hi stays 0x12345678, lo unchanged.
REQ-033 start mult, assert mtlo a=0xAAAAAAAA in busy cycle 2 -> mtlo ignored, lo shows the product after cycle 5.
REQ-034 start div, assert reset in busy cycle 4 -> busy, hi, lo go 0 without waiting for a clock edge; no result ever appears.
